// File: rtl/lz4_pkg.sv
// Shared constants, FSM state type and token helpers for the LZ4 sequence encoder.
package lz4_pkg;

  localparam int unsigned LZ4_MIN_MATCH = 4;
  localparam int unsigned NIBBLE_MAX    = 15;
  localparam int unsigned EXT_BYTE      = 255;

  localparam int unsigned TOKEN_LIT_MSB   = 7;
  localparam int unsigned TOKEN_LIT_LSB   = 4;
  localparam int unsigned TOKEN_MATCH_MSB = 3;
  localparam int unsigned TOKEN_MATCH_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_LIT_EXT,
    S_LIT,
    S_OFF_LO,
    S_OFF_HI,
    S_ML_EXT,
    S_FLUSH
  } state_t;

  function automatic logic [3:0] sat_nibble(input logic [31:0] v);
    return (v >= NIBBLE_MAX) ? 4'(NIBBLE_MAX) : v[3:0];
  endfunction

endpackage

// File: rtl/lz4_sequence_encoder_len_ext.sv
// Length-extension byte generator: emits 0xFF runs then the remainder byte.
module lz4_len_ext
  import lz4_pkg::*;
#(
  parameter int unsigned len_size = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [len_size-1:0] rem_in,
  input  logic                advance,
  output logic [7:0]          ext_byte,
  output logic                is_final
);

  logic [len_size-1:0] rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
    end else if (load) begin
      rem <= rem_in;
    end else if (advance && !is_final) begin
      rem <= rem - len_size'(EXT_BYTE);
    end
  end

  assign is_final = (rem < len_size'(EXT_BYTE));
  assign ext_byte = is_final ? rem[7:0] : 8'(EXT_BYTE);

endmodule

// File: rtl/lz4_sequence_encoder.sv
// Serialises LZ4 sequence commands plus a literal stream into the LZ4 block byte stream.
module lz4_sequence_encoder
  import lz4_pkg::*;
#(
  parameter int unsigned word_size   = 8,
  parameter int unsigned len_size    = 16,
  parameter int unsigned offset_size = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   seq_valid,
  output logic                   seq_ready,
  input  logic [len_size-1:0]    seq_lit_len,
  input  logic [len_size-1:0]    seq_match_len,
  input  logic [offset_size-1:0] seq_offset,
  input  logic                   seq_last,
  input  logic [word_size-1:0]   lit_data,
  input  logic                   lit_valid,
  output logic                   lit_ready,
  output logic [word_size-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   block_done,
  output logic                   err
);

  state_t state, state_nx;

  logic                   armed;
  logic [len_size-1:0]    ll, ml;
  logic [offset_size-1:0] off;
  logic                   last;

  logic                   load_ok, emit, cmd_fire, cmd_legal, lit_fire;
  logic [word_size-1:0]   emit_byte;
  logic                   ext_load, ext_adv, ext_final;
  logic [len_size-1:0]    ext_rem_in;
  logic [7:0]             ext_byte;

  assign load_ok   = !out_valid || out_ready;
  assign cmd_fire  = seq_valid && seq_ready;
  assign cmd_legal = seq_last ||
                     ((seq_match_len >= len_size'(LZ4_MIN_MATCH)) && (seq_offset != '0));
  assign lit_fire  = lit_valid && lit_ready;

  lz4_len_ext #(.len_size(len_size)) u_len_ext (
    .clk      (clk),
    .reset    (reset),
    .load     (ext_load),
    .rem_in   (ext_rem_in),
    .advance  (ext_adv),
    .ext_byte (ext_byte),
    .is_final (ext_final)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cmd_fire && cmd_legal) state_nx = S_TOKEN;
      S_TOKEN:
        if (load_ok) begin
          if (ll >= len_size'(NIBBLE_MAX)) state_nx = S_LIT_EXT;
          else if (ll == '0)               state_nx = S_OFF_LO;
          else                             state_nx = S_LIT;
        end
      S_LIT_EXT:
        if (load_ok && ext_final) state_nx = (ll == '0) ? S_OFF_LO : S_LIT;
      S_LIT:     if (lit_fire && (ll == len_size'(1))) state_nx = S_OFF_LO;
      S_OFF_LO:  if (load_ok) state_nx = S_OFF_HI;
      S_OFF_HI:
        if (load_ok) begin
          if (last)                             state_nx = S_FLUSH;
          else if (ml >= len_size'(NIBBLE_MAX)) state_nx = S_ML_EXT;
          else                                  state_nx = S_IDLE;
        end
      S_ML_EXT:  if (load_ok && ext_final) state_nx = S_IDLE;
      S_FLUSH:   if (out_valid && out_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    seq_ready  = (state == S_IDLE) && armed;
    lit_ready  = 1'b0;
    emit       = 1'b0;
    emit_byte  = '0;
    ext_load   = 1'b0;
    ext_adv    = 1'b0;
    ext_rem_in = ll - len_size'(NIBBLE_MAX);
    block_done = 1'b0;
    case (state)
      S_TOKEN: begin
        emit      = 1'b1;
        emit_byte = {sat_nibble(32'(ll)), sat_nibble(32'(ml))};
        ext_load  = load_ok && (ll >= len_size'(NIBBLE_MAX));
      end
      S_LIT_EXT: begin
        emit      = 1'b1;
        emit_byte = ext_byte;
        ext_adv   = load_ok;
      end
      S_LIT: begin
        lit_ready = load_ok;
        emit      = lit_valid;
        emit_byte = lit_data;
      end
      S_OFF_LO: begin
        emit      = 1'b1;
        emit_byte = last ? '0 : off[7:0];
      end
      S_OFF_HI: begin
        emit       = 1'b1;
        emit_byte  = last ? '0 : off[15:8];
        ext_load   = load_ok && !last && (ml >= len_size'(NIBBLE_MAX));
        ext_rem_in = ml - len_size'(NIBBLE_MAX);
      end
      S_ML_EXT: begin
        emit      = 1'b1;
        emit_byte = ext_byte;
        ext_adv   = load_ok;
      end
      S_FLUSH:   block_done = out_valid && out_ready;
      default: ;
    endcase
  end

  // armed holds seq_ready low for the first cycle out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      ll        <= '0;
      ml        <= '0;
      off       <= '0;
      last      <= 1'b0;
      err       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (cmd_fire) begin
        if (cmd_legal) begin
          ll   <= seq_lit_len;
          ml   <= seq_last ? '0 : seq_match_len - len_size'(LZ4_MIN_MATCH);
          off  <= seq_offset;
          last <= seq_last;
        end else begin
          err <= 1'b1;
        end
      end
      if (lit_fire) ll <= ll - len_size'(1);
      if (emit && load_ok) begin
        out_data  <= emit_byte;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lz4_sequence_encoder.sv
// Self-checking bench: table vectors, randomized commands with stalls, reset and error cases.
module tb_lz4_sequence_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        seq_valid;
  logic        seq_ready;
  logic [15:0] seq_lit_len;
  logic [15:0] seq_match_len;
  logic [15:0] seq_offset;
  logic        seq_last;
  logic [7:0]  lit_data;
  logic        lit_valid;
  logic        lit_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        block_done;
  logic        err;

  lz4_sequence_encoder #(.word_size(8), .len_size(16), .offset_size(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .seq_valid     (seq_valid),
    .seq_ready     (seq_ready),
    .seq_lit_len   (seq_lit_len),
    .seq_match_len (seq_match_len),
    .seq_offset    (seq_offset),
    .seq_last      (seq_last),
    .lit_data      (lit_data),
    .lit_valid     (lit_valid),
    .lit_ready     (lit_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .block_done    (block_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] lit_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         done_cnt;
  int         done_idx;
  bit         rand_rdy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;

  typedef struct {
    int ll;
    int ml;
    int off;
    bit last;
    int tok;
    int len;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (block_done) begin
          done_cnt++;
          done_idx = got_q.size() - 1;
        end
      end else if (block_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_no_handshake: got 1 expected 0");
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  function automatic void push_ext(input int r0);
    int r = r0;
    while (r >= 255) begin
      exp_q.push_back(8'hFF);
      r -= 255;
    end
    exp_q.push_back(8'(r));
  endfunction

  function automatic void model(input int ll, input int ml, input int off, input bit last);
    int mlp = last ? 0 : ml - 4;
    exp_q.push_back(8'((((ll > 15) ? 15 : ll) << 4) | ((mlp > 15) ? 15 : mlp)));
    if (ll >= 15) push_ext(ll - 15);
    foreach (lit_q[i]) exp_q.push_back(lit_q[i]);
    exp_q.push_back(last ? 8'h00 : 8'(off));
    exp_q.push_back(last ? 8'h00 : 8'(off >> 8));
    if (!last && mlp >= 15) push_ext(mlp - 15);
  endfunction

  task automatic send_cmd(input int ll, input int ml, input int off, input bit last);
    int guard = 0;
    @(posedge clk);
    #1;
    seq_valid     = 1'b1;
    seq_lit_len   = 16'(ll);
    seq_match_len = 16'(ml);
    seq_offset    = 16'(off);
    seq_last      = last;
    forever begin
      @(negedge clk);
      if (seq_ready || guard > 200) break;
      guard++;
    end
    if (!seq_ready) check("cmd_timeout", 0, 1);
    @(posedge clk);
    #1;
    seq_valid = 1'b0;
  endtask

  task automatic send_lits(input bit stall);
    int i = 0;
    int guard = 0;
    while (i < lit_q.size() && guard < 20000) begin
      @(posedge clk);
      #1;
      lit_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      lit_data  = lit_q[i];
      @(negedge clk);
      if (lit_valid && lit_ready) i++;
      guard++;
    end
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
    if (i < lit_q.size()) check("lit_timeout", i, lit_q.size());
  endtask

  task automatic run(input int ll, input int ml, input int off, input bit last,
                     input bit stall, input bit rnd_lits, input int tok, input int len,
                     input bit use_tbl);
    int c = 0;
    lit_q.delete();
    exp_q.delete();
    got_q.delete();
    done_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < ll; i++) lit_q.push_back(rnd_lits ? 8'($urandom) : 8'(8'h61 + i));
    model(ll, ml, off, last);
    rand_rdy = stall;
    fork
      send_cmd(ll, ml, off, last);
      send_lits(stall);
    join
    while (got_q.size() < exp_q.size() && c < 5000) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    rand_rdy = 1'b0;
    check("length", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        check($sformatf("byte[%0d]", i), got_q[i], exp_q[i]);
        break;
      end
    end
    n_cmp++;
    if (use_tbl) begin
      check("tbl_token", (got_q.size() > 0) ? got_q[0] : 32'hDEAD, tok);
      check("tbl_length", got_q.size(), len);
    end
    check("done_count", done_cnt, last ? 1 : 0);
    if (last) check("done_index", done_idx, exp_q.size() - 1);
  endtask

  initial begin
    tbl[0] = '{ll: 3,   ml: 4,   off: 'h0001, last: 0, tok: 'h30, len: 6};
    tbl[1] = '{ll: 15,  ml: 19,  off: 'h1234, last: 0, tok: 'hFF, len: 20};
    tbl[2] = '{ll: 300, ml: 4,   off: 'h0010, last: 0, tok: 'hF0, len: 305};
    tbl[3] = '{ll: 5,   ml: 0,   off: 'h0000, last: 1, tok: 'h50, len: 8};
    tbl[4] = '{ll: 0,   ml: 4,   off: 'h0005, last: 0, tok: 'h00, len: 3};
    tbl[5] = '{ll: 14,  ml: 18,  off: 'hABCD, last: 0, tok: 'hEE, len: 17};
    tbl[6] = '{ll: 270, ml: 274, off: 'h0102, last: 0, tok: 'hFF, len: 277};
    tbl[7] = '{ll: 0,   ml: 9,   off: 'h7777, last: 1, tok: 'h00, len: 3};

    reset = 1'b1;
    seq_valid = 1'b0; seq_lit_len = '0; seq_match_len = '0; seq_offset = '0; seq_last = 1'b0;
    lit_valid = 1'b0; lit_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_seq_ready", seq_ready, 0);
    check("rst_lit_ready", lit_ready, 0);
    check("rst_block_done", block_done, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int t = 0; t < 8; t++)
      run(tbl[t].ll, tbl[t].ml, tbl[t].off, tbl[t].last, 1'b0, 1'b0, tbl[t].tok, tbl[t].len, 1'b1);
    run(tbl[2].ll, tbl[2].ml, tbl[2].off, tbl[2].last, 1'b1, 1'b0, tbl[2].tok, tbl[2].len, 1'b1);

    for (int k = 0; k < 20; k++) begin
      int ll, ml;
      ll = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 600) : $urandom_range(0, 40);
      ml = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 600) : $urandom_range(4, 22);
      run(ll, ml, $urandom_range(1, 65535), $urandom_range(0, 4) == 0, 1'b1, 1'b1, 0, 0, 1'b0);
    end

    got_q.delete();
    send_cmd(2, 3, 1, 1'b0);
    repeat (5) @(negedge clk);
    check("illegal_ml_err", err, 1);
    check("illegal_ml_bytes", got_q.size(), 0);
    check("illegal_ml_ready", seq_ready, 1);
    send_cmd(2, 8, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("illegal_off_bytes", got_q.size(), 0);

    lit_q.delete();
    for (int i = 0; i < 20; i++) lit_q.push_back(8'(i));
    send_cmd(20, 4, 1, 1'b0);
    for (int c = 0; c < 200 && got_q.size() < 5; c++) begin
      @(posedge clk);
      #1;
      lit_valid = 1'b1;
      lit_data  = 8'hA5;
      @(negedge clk);
    end
    check("pre_reset_progress", got_q.size() >= 5, 1);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    lit_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err", err, 0);
    check("midrst_lit_ready", lit_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    repeat (6) @(negedge clk);
    check("post_reset_silent", got_q.size(), 0);
    run(tbl[0].ll, tbl[0].ml, tbl[0].off, tbl[0].last, 1'b0, 1'b0, tbl[0].tok, tbl[0].len, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
